// File: rtl/cart_bus_master.sv
// cart_bus_master: console-side initiator for the cartridge bus.
// Turns a command/response handshake into timed nSel/nIO/nOE/nWE cycles
// and generates the free-running SClk cartridge clock.
// Optional multi-beat auto-increment build: define CART_BUS_AUTOINC_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | bus released, CmdReady high, waiting for a command
// S_SETUP  | nSel/nIO/address (and write data) valid ahead of the strobe
// S_STROBE | nOE (read) or nWE (write) low; read data sampled on last cycle
// S_HOLD   | strobe released, select/address/data still held
// S_GAP    | one released cycle between auto-increment beats
module cart_bus_master #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 1,
    parameter int SCLK_DIV   = 32
) (
    input  logic        FastClk,
    input  logic        nReset,
    input  logic        CmdValid,
    output logic        CmdReady,
    input  logic        CmdWrite,
    input  logic        CmdIO,
    input  logic        CmdByte,
    input  logic [19:0] CmdAddr,
    input  logic [15:0] CmdData,
    input  logic [7:0]  CmdCount,
    output logic        RspValid,
    output logic [15:0] RspData,
    output logic [19:0] Addr,
    output logic [15:0] DataOut,
    output logic        DataOELo,
    output logic        DataOEHi,
    input  logic [15:0] DataIn,
    output logic        nSel,
    output logic        nIO,
    output logic        nOE,
    output logic        nWE,
    output logic        SClk
);

    localparam int MAX_A = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAX_PH = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
    localparam int CW = $clog2(MAX_PH + 1);
    localparam int SW = $clog2(SCLK_DIV + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic          io_q, io_d;
    logic          byte_q, byte_d;
    logic [19:0]   addr_q, addr_d;
    logic [15:0]   dout_q, dout_d;
    logic [15:0]   cap_q, cap_d;
    logic [7:0]    beats_q, beats_d;
    logic          rsp_v_q, rsp_v_d;
    logic [15:0]   rsp_data_q, rsp_data_d;
    logic [SW-1:0] sclk_cnt_q;
    logic          sclk_q;
    logic          busy;
    logic [19:0]   addr_next;

`ifdef CART_BUS_AUTOINC_EN
    logic [7:0] beats_load;
    assign beats_load = CmdCount;
`else
    logic [7:0] beats_load;
    logic       unused_cmd_count;
    assign beats_load       = 8'd0;
    assign unused_cmd_count = ^CmdCount;
`endif

    // IO addresses only ever carry 8 significant bits, so they wrap there.
    assign addr_next = io_q ? {12'h000, addr_q[7:0] + 8'd1}
                            : addr_q + (byte_q ? 20'd1 : 20'd2);

    // Next-state, phase timer and command/response bookkeeping.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        io_d       = io_q;
        byte_d     = byte_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        cap_d      = cap_q;
        beats_d    = beats_q;
        rsp_v_d    = 1'b0;
        rsp_data_d = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (CmdValid) begin
                    wr_d    = CmdWrite;
                    io_d    = CmdIO;
                    byte_d  = CmdByte;
                    addr_d  = CmdIO ? {12'h000, CmdAddr[7:0]} : CmdAddr;
                    if (CmdWrite) dout_d = CmdData;
                    beats_d = beats_load;
                    cnt_d   = CW'(SETUP_CYC - 1);
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = CW'(STROBE_CYC - 1);
                    state_d = S_STROBE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_STROBE: begin
                if (cnt_q == '0) begin
                    if (!wr_q) cap_d = DataIn;
                    cnt_d   = CW'(HOLD_CYC - 1);
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    rsp_v_d = 1'b1;
                    if (wr_q)                rsp_data_d = 16'h0000;
                    else if (byte_q || io_q) rsp_data_d = {8'h00, cap_q[7:0]};
                    else                     rsp_data_d = cap_q;
                    if (beats_q != 8'd0) begin
                        beats_d = beats_q - 8'd1;
                        addr_d  = addr_next;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_GAP: begin
                cnt_d   = CW'(SETUP_CYC - 1);
                state_d = S_SETUP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus state registers; reset drops any in-flight access.
    always_ff @(posedge FastClk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            io_q       <= 1'b0;
            byte_q     <= 1'b0;
            addr_q     <= 20'h00000;
            dout_q     <= 16'h0000;
            cap_q      <= 16'h0000;
            beats_q    <= 8'd0;
            rsp_v_q    <= 1'b0;
            rsp_data_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            io_q       <= io_d;
            byte_q     <= byte_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            cap_q      <= cap_d;
            beats_q    <= beats_d;
            rsp_v_q    <= rsp_v_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Free-running SClk divider, unrelated to bus activity.
    always_ff @(posedge FastClk or negedge nReset) begin
        if (!nReset) begin
            sclk_cnt_q <= SW'(SCLK_DIV - 1);
            sclk_q     <= 1'b0;
        end else if (sclk_cnt_q == '0) begin
            sclk_cnt_q <= SW'(SCLK_DIV - 1);
            sclk_q     <= ~sclk_q;
        end else begin
            sclk_cnt_q <= sclk_cnt_q - SW'(1);
        end
    end

    assign busy     = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);
    assign CmdReady = (state_q == S_IDLE);
    assign nSel     = ~busy;
    assign nIO      = busy ? ~io_q : 1'b1;
    assign nOE      = ~((state_q == S_STROBE) && !wr_q);
    assign nWE      = ~((state_q == S_STROBE) && wr_q);
    assign DataOELo = busy && wr_q;
    assign DataOEHi = busy && wr_q && !byte_q && !io_q;
    assign Addr     = addr_q;
    assign DataOut  = dout_q;
    assign RspValid = rsp_v_q;
    assign RspData  = rsp_data_q;
    assign SClk     = sclk_q;

endmodule

// File: tb/tb_cart_bus_master.sv
// Directed bench for cart_bus_master: a vector table of single accesses
// plus hand-written back-to-back, reset-abort, SClk and multi-beat sequences.
module tb_cart_bus_master;

    logic        FastClk = 1'b0;
    logic        nReset  = 1'b0;
    logic        CmdValid = 1'b0;
    logic        CmdReady;
    logic        CmdWrite = 1'b0;
    logic        CmdIO    = 1'b0;
    logic        CmdByte  = 1'b0;
    logic [19:0] CmdAddr  = 20'h0;
    logic [15:0] CmdData  = 16'h0;
    logic [7:0]  CmdCount = 8'h0;
    logic        RspValid;
    logic [15:0] RspData;
    logic [19:0] Addr;
    logic [15:0] DataOut;
    logic        DataOELo, DataOEHi;
    logic [15:0] DataIn = 16'h5A5A;
    logic        nSel, nIO, nOE, nWE, SClk;

    int tests = 0;
    int fails = 0;

    cart_bus_master dut (
        .FastClk(FastClk), .nReset(nReset),
        .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdWrite(CmdWrite),
        .CmdIO(CmdIO), .CmdByte(CmdByte), .CmdAddr(CmdAddr),
        .CmdData(CmdData), .CmdCount(CmdCount),
        .RspValid(RspValid), .RspData(RspData),
        .Addr(Addr), .DataOut(DataOut), .DataOELo(DataOELo), .DataOEHi(DataOEHi),
        .DataIn(DataIn), .nSel(nSel), .nIO(nIO), .nOE(nOE), .nWE(nWE), .SClk(SClk)
    );

    always #5 FastClk = ~FastClk;

    typedef struct {
        logic        wr;
        logic        io;
        logic        byt;
        logic [19:0] addr;
        logic [15:0] data;
        logic [15:0] din;
        logic [19:0] exp_addr;
        logic        exp_lo;
        logic        exp_hi;
        logic [15:0] exp_rsp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (CmdReady !== 1'b1 && n < 40) begin
            @(negedge FastClk);
            n++;
        end
        check("wait_ready", 32'(CmdReady), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int nsel_cnt = 0, s_first = 0, s_cnt = 0, addr_err = 0, oe_err = 0;
        int nio_err = 0, dout_err = 0, bad = 0, rsp_k = 0, rsp_cnt = 0;
        logic [15:0] rsp_val = 16'h0;
        wait_ready();
        CmdValid = 1'b1; CmdWrite = v.wr; CmdIO = v.io; CmdByte = v.byt;
        CmdAddr = v.addr; CmdData = v.data; CmdCount = 8'd0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge FastClk);
            if (k == 1) begin
                CmdValid = 1'b0; CmdWrite = ~v.wr; CmdIO = ~v.io; CmdByte = ~v.byt;
                CmdAddr = ~v.addr; CmdData = ~v.data;
            end
            DataIn = (nOE == 1'b0) ? v.din : 16'h5A5A;
            if (!nSel) begin
                nsel_cnt++;
                if (Addr !== v.exp_addr) addr_err++;
                if (DataOELo !== v.exp_lo || DataOEHi !== v.exp_hi) oe_err++;
                if (nIO !== ~v.io) nio_err++;
                if (v.wr && DataOut !== v.data) dout_err++;
            end else if (DataOELo || DataOEHi || !nIO) begin
                oe_err++;
            end
            if (v.wr ? !nWE : !nOE) begin
                if (s_first == 0) s_first = k;
                s_cnt++;
            end
            if (v.wr ? !nOE : !nWE) bad++;
            if ((!nOE || !nWE) && nSel) bad++;
            if (RspValid) begin
                rsp_cnt++;
                if (rsp_k == 0) begin rsp_k = k; rsp_val = RspData; end
            end
        end
        DataIn = 16'h5A5A;
        check("nsel_low_cycles", 32'(nsel_cnt), 32'd7);
        check("strobe_first", 32'(s_first), 32'd3);
        check("strobe_cycles", 32'(s_cnt), 32'd4);
        check("addr_err", 32'(addr_err), 32'd0);
        check("data_oe_err", 32'(oe_err), 32'd0);
        check("nio_err", 32'(nio_err), 32'd0);
        check("dataout_err", 32'(dout_err), 32'd0);
        check("bus_order_err", 32'(bad), 32'd0);
        check("rsp_cycle", 32'(rsp_k), 32'd8);
        check("rsp_count", 32'(rsp_cnt), 32'd1);
        check("rsp_data", 32'(rsp_val), 32'(v.exp_rsp));
        check("rsp_data_hold", 32'(RspData), 32'(v.exp_rsp));
    endtask

    initial begin
        int rsp_cnt, rsp2_k, ready8, nsel_hi, n, per;
        logic s0;

        //        wr    io    byt   addr      data      din       exp_addr  lo    hi    rsp
        vecs[0] = '{1'b1, 1'b1, 1'b0, 20'h000C2, 16'h0055, 16'h0000, 20'h000C2, 1'b1, 1'b0, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 20'h20000, 16'h0000, 16'hBEEF, 20'h20000, 1'b0, 1'b0, 16'hBEEF};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 20'h00101, 16'h0000, 16'h12AB, 20'h00101, 1'b0, 1'b0, 16'h00AB};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 20'h12345, 16'h0000, 16'hA55A, 20'h00045, 1'b0, 1'b0, 16'h005A};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 20'h31234, 16'hA5C3, 16'h0000, 20'h31234, 1'b1, 1'b1, 16'h0000};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 20'hFFFFF, 16'h007E, 16'h0000, 20'hFFFFF, 1'b1, 1'b0, 16'h0000};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 20'hABCDE, 16'h0000, 16'h0F0F, 20'hABCDE, 1'b0, 1'b0, 16'h0F0F};

        // reset values
        #23;
        check("rst_nSel", 32'(nSel), 32'd1);
        check("rst_strobes", 32'({nIO, nOE, nWE}), 32'h7);
        check("rst_addr", 32'(Addr), 32'd0);
        check("rst_dataout", 32'(DataOut), 32'd0);
        check("rst_oe", 32'({DataOELo, DataOEHi}), 32'd0);
        check("rst_ready", 32'(CmdReady), 32'd1);
        check("rst_rsp", 32'({RspValid, RspData}), 32'd0);
        check("rst_sclk", 32'(SClk), 32'd0);
        @(negedge FastClk);
        nReset = 1'b1;
        @(negedge FastClk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // back-to-back: CmdValid held across two commands
        wait_ready();
        CmdValid = 1'b1; CmdWrite = 1'b1; CmdIO = 1'b0; CmdByte = 1'b0;
        CmdAddr = 20'h00010; CmdData = 16'h1111; CmdCount = 8'd0;
        rsp_cnt = 0; rsp2_k = 0; ready8 = 0; nsel_hi = 0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge FastClk);
            if (k <= 15 && nSel) nsel_hi++;
            if (RspValid) begin
                rsp_cnt++;
                if (rsp_cnt == 2) rsp2_k = k;
            end
            if (k == 8) ready8 = int'(CmdReady && RspValid);
            if (k == 9) CmdValid = 1'b0;
        end
        check("b2b_ready_on_rsp", 32'(ready8), 32'd1);
        check("b2b_nsel_gap", 32'(nsel_hi), 32'd1);
        check("b2b_rsp_count", 32'(rsp_cnt), 32'd2);
        check("b2b_rsp2_cycle", 32'(rsp2_k), 32'd16);

        // reset asserted mid-STROBE
        wait_ready();
        CmdValid = 1'b1; CmdWrite = 1'b1; CmdIO = 1'b0; CmdByte = 1'b0;
        CmdAddr = 20'h40000; CmdData = 16'h7777;
        for (int k = 1; k <= 4; k++) begin
            @(negedge FastClk);
            if (k == 1) CmdValid = 1'b0;
        end
        check("mid_nwe_low", 32'(nWE), 32'd0);
        nReset = 1'b0;
        #1;
        check("mid_rst_sel", 32'({nSel, nIO, nOE, nWE}), 32'hF);
        check("mid_rst_oe", 32'({DataOELo, DataOEHi}), 32'd0);
        check("mid_rst_addr", 32'(Addr), 32'd0);
        @(negedge FastClk);
        nReset = 1'b1;
        rsp_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge FastClk);
            if (RspValid) rsp_cnt++;
        end
        check("mid_rst_no_rsp", 32'(rsp_cnt), 32'd0);
        check("mid_rst_ready", 32'(CmdReady), 32'd1);

        // SClk half-period
        s0 = SClk; n = 0;
        while (SClk == s0 && n < 80) begin @(negedge FastClk); n++; end
        s0 = SClk; per = 0;
        while (SClk == s0 && per < 80) begin @(negedge FastClk); per++; end
        check("sclk_half_period", 32'(per), 32'd32);

`ifdef CART_BUS_AUTOINC_EN
        begin
            logic [19:0] a_seen[3];
            int na = 0, ready_err = 0, rk[3];
            logic prev_sel = 1'b1;
            logic [15:0] last_rsp = 16'h0;
            rsp_cnt = 0;
            wait_ready();
            CmdValid = 1'b1; CmdWrite = 1'b0; CmdIO = 1'b0; CmdByte = 1'b0;
            CmdAddr = 20'hFFFFE; CmdCount = 8'd2;
            for (int k = 1; k <= 30; k++) begin
                @(negedge FastClk);
                if (k == 1) begin CmdValid = 1'b0; CmdCount = 8'd0; end
                DataIn = (nOE == 1'b0) ? 16'h1234 : 16'h5A5A;
                if (prev_sel && !nSel && na < 3) begin a_seen[na] = Addr; na++; end
                prev_sel = nSel;
                if (RspValid && rsp_cnt < 3) begin rk[rsp_cnt] = k; rsp_cnt++; last_rsp = RspData; end
                if (rsp_cnt < 3 && CmdReady) ready_err++;
            end
            DataIn = 16'h5A5A;
            check("ai_beats", 32'(na), 32'd3);
            check("ai_addr0", 32'(a_seen[0]), 32'hFFFFE);
            check("ai_addr1", 32'(a_seen[1]), 32'h00000);
            check("ai_addr2", 32'(a_seen[2]), 32'h00002);
            check("ai_rsp_count", 32'(rsp_cnt), 32'd3);
            check("ai_rsp_k2", 32'(rk[2]), 32'd24);
            check("ai_ready_err", 32'(ready_err), 32'd0);
            check("ai_rsp_data", 32'(last_rsp), 32'h1234);
        end
`else
        begin
            rsp_cnt = 0;
            wait_ready();
            CmdValid = 1'b1; CmdWrite = 1'b0; CmdIO = 1'b0; CmdByte = 1'b0;
            CmdAddr = 20'h00200; CmdCount = 8'd3;
            for (int k = 1; k <= 30; k++) begin
                @(negedge FastClk);
                if (k == 1) begin CmdValid = 1'b0; CmdCount = 8'd0; end
                if (RspValid) rsp_cnt++;
            end
            check("count_ignored", 32'(rsp_cnt), 32'd1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cart_bus_master.md
Name: cart_bus_master

Overview:
- Synthesizable initiator for the cartridge bus. It plays the console side of the bus that the nileswan mapper responds to.
- It turns a simple command/response handshake into timed nSel/nIO/nOE/nWE/address/data cycles, and generates the free-running SClk cartridge clock.
- Uses: bench/bring-up adapter and an in-FPGA loopback master for exercising mapper registers, PSRAM, SRAM, boot ROM and SPI buffers.

Parameters:
- SETUP_CYC, 2, FastClk cycles with address/nSel/nIO valid before the strobe falls (min 1).
- STROBE_CYC, 4, FastClk cycles nOE or nWE held low (min 1).
- HOLD_CYC, 1, FastClk cycles after the strobe rises with nSel low and address/write data held (min 1).
- SCLK_DIV, 32, FastClk cycles per SClk half-period (min 1).

Ports:
- FastClk  input  1  sole clock.
- nReset  input  1  asynchronous, active-low reset.
- CmdValid  input  1  command offered.
- CmdReady  output  1  block can accept a command.
- CmdWrite  input  1  1 = write, 0 = read.
- CmdIO  input  1  1 = IO space (nIO low), 0 = memory space.
- CmdByte  input  1  1 = 8-bit access on Data[7:0] only.
- CmdAddr  input  20  bus address.
- CmdData  input  16  write data.
- CmdCount  input  8  extra beats (autoinc feature only).
- RspValid  output  1  one-cycle pulse at the end of each beat.
- RspData  output  16  read data; 0 for writes.
- Addr  output  20  cartridge address bus.
- DataOut  output  16  write data to pads.
- DataOELo  output  1  drive enable for Data[7:0].
- DataOEHi  output  1  drive enable for Data[15:8].
- DataIn  input  16  pad input data.
- nSel  output  1  cartridge select.
- nIO  output  1  IO-space select.
- nOE  output  1  read strobe.
- nWE  output  1  write strobe.
- SClk  output  1  divided cartridge clock.

Behaviour:
- Reset values: nSel=nIO=nOE=nWE=1, Addr=0, DataOut=0, DataOELo=DataOEHi=0, CmdReady=1, RspValid=0, RspData=0, SClk=0, state=IDLE.
- Assertion of nReset forces these values immediately, including mid-access; the in-flight access is dropped with no RspValid.
- States: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
- IDLE:
  - nSel=nIO=nOE=nWE=1; DataOE low.
  - CmdReady=1; accepts when CmdValid & CmdReady. Call this cycle T.
  - All Cmd* fields are registered at T; later input changes are ignored.
- SETUP, entered at T+1, lasts SETUP_CYC cycles:
  - nSel=0; nIO=~CmdIO.
  - Addr = CmdAddr for memory; Addr = {12'h0, CmdAddr[7:0]} for IO.
  - On writes: DataOut = CmdData, DataOELo=1, DataOEHi = ~CmdByte & ~CmdIO.
- STROBE, lasts STROBE_CYC cycles:
  - nOE=0 for reads, nWE=0 for writes; everything else held.
  - Reads register DataIn on the last STROBE cycle.
- HOLD, lasts HOLD_CYC cycles: strobe back high; nSel, nIO, Addr and write data held.
- Return to IDLE:
  - RspValid pulses in the first IDLE cycle.
  - Read RspData = captured word; byte or IO reads return {8'h00, captured[7:0]}. Write RspData = 0.
  - RspData holds until the next RspValid.
- Access timing:
  - Total access = SETUP_CYC + STROBE_CYC + HOLD_CYC cycles with nSel low.
  - nSel is guaranteed high for at least 1 cycle between accesses (the IDLE cycle).
  - A new command may be accepted in the same cycle RspValid pulses.
- Bus ordering rules:
  - nOE and nWE are never low simultaneously.
  - Neither strobe is low while nSel is high.
  - Address and DataOE never change while a strobe is low.
- Counters: phase counter wide enough for the maximum of the three phase parameters; reloads on every phase entry.
- SClk: free-running, toggles every SCLK_DIV FastClk cycles, independent of bus state. Not an internal clock.

Optional Feature:
- Macro: CART_BUS_AUTOINC_EN.
- Enabled:
  - An accepted command performs CmdCount+1 beats.
  - After each beat's RspValid, Addr advances by 1 (byte or IO) or 2 (word). The 20-bit address wraps 0xFFFFF->0x00000; IO addresses wrap within 8 bits.
  - Between beats the block spends one IDLE-like cycle with nSel=1 and CmdReady=0.
  - Writes reuse CmdData for every beat.
  - CmdReady rises only after the final beat.
- Disabled: CmdCount is ignored; every command is exactly one beat.

Test Plan:
- Reset and IO write, defaults: CmdIO=1, CmdWrite=1, CmdAddr=0xC2, CmdData=0x0055.
  - nIO and nSel low 7 cycles; nWE low cycles 3-6 after acceptance; Addr=0x000C2.
  - DataOELo=1, DataOEHi=0.
  - RspValid at T+8 with RspData=0.
- Memory word read: Addr=0x2_0000, bench drives DataIn=0xBEEF during STROBE -> RspData=0xBEEF; nOE low 4 cycles; DataOE stay 0 throughout.
- Byte read, DataIn=0x12AB -> RspData=0x00AB.
- Back-to-back: CmdValid held high for two commands -> second accepted on the RspValid cycle; nSel high exactly 1 cycle between accesses.
- Reset mid-STROBE -> all strobes and nSel high immediately, DataOE=0, no RspValid, CmdReady=1 after release.
- CART_BUS_AUTOINC_EN: word read at 0xFFFFE with CmdCount=2 -> three RspValid pulses, Addr 0xFFFFE, 0x00000, 0x00002; CmdReady low until the third pulse.
